// File: rtl/prog_loader_pkg.sv
//------------------------------------------------------------------------------
// prog_loader_pkg : state encoding and length decode shared by the loader.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

package prog_loader_pkg;

   localparam int unsigned STATE_W = 3;

   localparam logic [STATE_W-1:0] S_IDLE = 3'd0;
   localparam logic [STATE_W-1:0] S_LEN  = 3'd1;
   localparam logic [STATE_W-1:0] S_DATA = 3'd2;
   localparam logic [STATE_W-1:0] S_CSUM = 3'd3;
   localparam logic [STATE_W-1:0] S_DONE = 3'd4;
   localparam logic [STATE_W-1:0] S_ERR  = 3'd5;

   // Same encoding as the localparams, for tools that decode enums in waves.
   typedef enum logic [STATE_W-1:0] {
      ST_IDLE = S_IDLE,
      ST_LEN  = S_LEN,
      ST_DATA = S_DATA,
      ST_CSUM = S_CSUM,
      ST_DONE = S_DONE,
      ST_ERR  = S_ERR
   } state_e;

   // A length byte of this value requests a full-memory load.
   localparam int unsigned LEN_FULL_CODE = 0;

   function automatic int unsigned decode_len(input int unsigned raw,
                                              input int unsigned addr_w);
      return (raw == LEN_FULL_CODE) ? (32'd1 << addr_w) : raw;
   endfunction

endpackage

`default_nettype wire

// File: rtl/prog_loader_memory_rw.sv
//------------------------------------------------------------------------------
// memory_rw : 2**ADDR_W x DATA_W storage, synchronous write, asynchronous read.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module memory_rw #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [DATA_W-1:0] o_rdata
);

   localparam int DEPTH = 2 ** ADDR_W;

   // Deliberately unreset: contents survive a reset of the loader.
   logic [DATA_W-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

`default_nettype wire

// File: rtl/prog_loader.sv
//------------------------------------------------------------------------------
// prog_loader : streams a length-prefixed program image into a CPU-readable
// memory. Optional trailing checksum enabled by PROG_LOADER_CHECKSUM_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W:0]   count
);

   logic [STATE_W-1:0] r_state;
   logic [ADDR_W-1:0]  r_wptr;
   logic [ADDR_W:0]    r_count;
   logic [ADDR_W:0]    r_len;

   logic               w_xfer;
   logic               w_we;
   logic               w_last;
   logic [ADDR_W:0]    w_len;
   logic [ADDR_W:0]    w_count_nx;

   assign in_ready = (r_state == S_LEN) || (r_state == S_DATA) || (r_state == S_CSUM);
   assign busy     = in_ready;
   assign done     = (r_state == S_DONE);
   assign count    = r_count;

   assign w_xfer     = in_valid && in_ready;
   assign w_we       = w_xfer && (r_state == S_DATA);
   assign w_count_nx = r_count + (ADDR_W+1)'(1);
   assign w_last     = (w_count_nx == r_len);
   assign w_len      = (ADDR_W+1)'(decode_len(32'(ADDR_W'(in_data)), ADDR_W));

`ifdef PROG_LOADER_CHECKSUM_EN
   logic [DATA_W-1:0] r_sum;
   logic [DATA_W-1:0] w_sum_nx;

   assign w_sum_nx = r_sum + in_data;
   assign err      = (r_state == S_ERR);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sum <= '0;
      end else if (start && !in_ready) begin
         r_sum <= '0;
      end else if (w_we) begin
         r_sum <= w_sum_nx;
      end
   end
`else
   assign err = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_wptr  <= '0;
         r_count <= '0;
         r_len   <= '0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE, S_ERR: begin
               if (start) begin
                  r_state <= S_LEN;
                  r_wptr  <= '0;
                  r_count <= '0;
               end
            end
            S_LEN: begin
               if (w_xfer) begin
                  r_len   <= w_len;
                  r_state <= S_DATA;
               end
            end
            S_DATA: begin
               if (w_xfer) begin
                  r_count <= w_count_nx;
                  // Pointer holds on the last word so a full load ends at the top address.
                  if (w_last) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                     r_state <= S_CSUM;
`else
                     r_state <= S_DONE;
`endif
                  end else begin
                     r_wptr <= r_wptr + ADDR_W'(1);
                  end
               end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            S_CSUM: begin
               if (w_xfer) begin
                  r_state <= (w_sum_nx == '0) ? S_DONE : S_ERR;
               end
            end
`endif
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   memory_rw #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_mem (
      .clk     (clk),
      .i_we    (w_we),
      .i_waddr (r_wptr),
      .i_wdata (in_data),
      .i_raddr (rd_addr),
      .o_rdata (rd_data)
   );

endmodule

`default_nettype wire
